// File: rtl/branch_cond_unit.sv
// branch_cond_unit
//   Branch resolve stage with a 2-bit saturating-counter branch history table.
//   Compares rs1/rs2, evaluates the funct3 branch condition, registers the
//   result (1-cycle latency) and trains the counter indexed by pc_ex.
//   A separate combinational lookup port predicts for the fetch PC.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   en, flush        stage enable (0 = stall), kill current resolve
//   valid_i          resolve request valid
//   Branch, funct3   conditional-branch flag and condition code
//   rs1, rs2         compare operands
//   pc_ex            PC of the resolving instruction (table update index)
//   pred_taken_i     prediction fetch made for this instruction
//   pc_if            fetch PC (table lookup index)
//   predict_taken    combinational lookup, MSB of counter[idx(pc_if)]
//   valid_o, passcond, taken_o, mispredict, illegal, Flags  registered results
module branch_cond_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 16,
    parameter int unsigned IDX_LSB   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            flush,
    input  logic            valid_i,
    input  logic            Branch,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] pc_ex,
    input  logic            pred_taken_i,
    input  logic [XLEN-1:0] pc_if,
    output logic            predict_taken,
    output logic            valid_o,
    output logic [1:0]      passcond,
    output logic            taken_o,
    output logic            mispredict,
    output logic            illegal,
    output logic [3:0]      Flags
);

    localparam int unsigned IW = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_e;

    logic [1:0]    bht [BHT_DEPTH];

    logic [XLEN:0] diff;
    logic          flag_n, flag_z, flag_c, flag_v, ge;
    logic          cond, legal, accept, update;
    logic [IW-1:0] idx_if, idx_ex;

    // Only the index field of each PC is consumed.
    logic          unused_pc_bits;
    assign unused_pc_bits = ^{pc_if, pc_ex};

    assign idx_if = pc_if[IDX_LSB +: IW];
    assign idx_ex = pc_ex[IDX_LSB +: IW];

    // Register-read semantics: a same-cycle update to this index is not
    // visible until the following cycle.
    assign predict_taken = bht[idx_if][1];

    always_comb begin
        diff   = {1'b0, rs1} - {1'b0, rs2};
        flag_n = diff[XLEN-1];
        flag_z = (diff[XLEN-1:0] == '0);
        flag_c = ~diff[XLEN];
        flag_v = (rs1[XLEN-1] != rs2[XLEN-1]) & (diff[XLEN-1] != rs1[XLEN-1]);
        ge     = (flag_n == flag_v);
    end

    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (funct3)
            F3_BEQ:  cond = flag_z;
            F3_BNE:  cond = ~flag_z;
            F3_BLT:  cond = ~ge;
            F3_BGE:  cond = ge;
            F3_BLTU: cond = ~flag_c;
            F3_BGEU: cond = flag_c;
            default: legal = 1'b0;
        endcase
    end

    assign accept = valid_i & en & ~flush;
    assign update = accept & Branch & legal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (update) begin
            if (cond && bht[idx_ex] != 2'b11) begin
                bht[idx_ex] <= bht[idx_ex] + 2'b01;
            end else if (!cond && bht[idx_ex] != 2'b00) begin
                bht[idx_ex] <= bht[idx_ex] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_o    <= 1'b0;
            passcond   <= 2'b00;
            taken_o    <= 1'b0;
            mispredict <= 1'b0;
            illegal    <= 1'b0;
            Flags      <= '0;
        end else if (flush) begin
            // passcond, taken_o and Flags deliberately hold
            valid_o    <= 1'b0;
            mispredict <= 1'b0;
            illegal    <= 1'b0;
        end else if (en) begin
            if (valid_i) begin
                valid_o <= 1'b1;
                Flags   <= {flag_n, flag_z, flag_c, flag_v};
                if (Branch && legal) begin
                    passcond   <= {2{cond}};
                    taken_o    <= cond;
                    mispredict <= cond ^ pred_taken_i;
                    illegal    <= 1'b0;
                end else begin
                    // non-branch and reserved-code branch resolve as not taken
                    passcond   <= 2'b11;
                    taken_o    <= 1'b0;
                    mispredict <= pred_taken_i;
                    illegal    <= Branch;
                end
            end else begin
                valid_o    <= 1'b0;
                mispredict <= 1'b0;
                illegal    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
module tb_branch_cond_unit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic        valid_i;
    logic        Branch;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc_ex;
    logic        pred_taken_i;
    logic [31:0] pc_if;
    logic        predict_taken;
    logic        valid_o;
    logic [1:0]  passcond;
    logic        taken_o;
    logic        mispredict;
    logic        illegal;
    logic [3:0]  Flags;

    branch_cond_unit #(.XLEN(32), .BHT_DEPTH(16), .IDX_LSB(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .valid_i(valid_i),
        .Branch(Branch), .funct3(funct3), .rs1(rs1), .rs2(rs2), .pc_ex(pc_ex),
        .pred_taken_i(pred_taken_i), .pc_if(pc_if), .predict_taken(predict_taken),
        .valid_o(valid_o), .passcond(passcond), .taken_o(taken_o),
        .mispredict(mispredict), .illegal(illegal), .Flags(Flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // expected {valid_o, passcond, taken_o, mispredict, illegal, Flags}
    logic [9:0] sbq[$];
    logic [1:0] mctr [16];
    logic       mv, mt, mmis, mill;
    logic [1:0] mpc;
    logic [3:0] mfl;
    bit         pred_known = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, model it, then compare after the edge.
    task automatic step(input string tag, input logic rst, input logic e, input logic fl,
                        input logic v, input logic br, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pcx, input logic pred, input logic [31:0] pcf);
        logic       c, lg, n, z, cf, vf;
        longint     sd;
        logic [31:0] d;
        logic [9:0] exp;
        rst_n = ~rst; en = e; flush = fl; valid_i = v; Branch = br; funct3 = f3;
        rs1 = a; rs2 = b; pc_ex = pcx; pred_taken_i = pred; pc_if = pcf;
        #1;
        if (pred_known) chk({tag, "_predict"}, {9'd0, predict_taken}, {9'd0, mctr[idx_of(pcf)][1]});

        d  = a - b;
        sd = longint'($signed(a)) - longint'($signed(b));
        n  = d[31];
        z  = (a == b);
        cf = (a >= b);
        vf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        lg = 1'b1;
        case (f3)
            3'b000: c = (a == b);
            3'b001: c = (a != b);
            3'b100: c = ($signed(a) < $signed(b));
            3'b101: c = ($signed(a) >= $signed(b));
            3'b110: c = (a < b);
            3'b111: c = (a >= b);
            default: begin c = 1'b0; lg = 1'b0; end
        endcase

        if (rst) begin
            mv = 0; mpc = 2'b00; mt = 0; mmis = 0; mill = 0; mfl = 4'h0;
            for (int i = 0; i < 16; i++) mctr[i] = 2'b01;
        end else if (fl) begin
            mv = 0; mmis = 0; mill = 0;
        end else if (e) begin
            if (v) begin
                mv = 1; mfl = {n, z, cf, vf};
                if (!br) begin
                    mpc = 2'b11; mt = 0; mmis = pred; mill = 0;
                end else if (!lg) begin
                    mpc = 2'b11; mt = 0; mmis = pred; mill = 1;
                end else begin
                    mpc = c ? 2'b11 : 2'b00; mt = c; mmis = (c != pred); mill = 0;
                    if (c && mctr[idx_of(pcx)] != 2'b11) mctr[idx_of(pcx)] = mctr[idx_of(pcx)] + 1;
                    if (!c && mctr[idx_of(pcx)] != 2'b00) mctr[idx_of(pcx)] = mctr[idx_of(pcx)] - 1;
                end
            end else begin
                mv = 0; mmis = 0; mill = 0;
            end
        end
        sbq.push_back({mv, mpc, mt, mmis, mill, mfl});

        @(posedge clk);
        #1;
        exp = sbq.pop_front();
        chk(tag, {valid_o, passcond, taken_o, mispredict, illegal, Flags}, exp);
        pred_known = 1;
    endtask

    initial begin
        rst_n = 0; en = 0; flush = 0; valid_i = 0; Branch = 0; funct3 = 3'b000;
        rs1 = '0; rs2 = '0; pc_ex = '0; pred_taken_i = 0; pc_if = '0;
        @(posedge clk);
        #1;

        // reset with a live request presented: request must be discarded
        step("reset", 1, 1, 0, 1, 1, 3'b000, 32'h5, 32'h5, 32'h0, 1, 32'h0);

        // every index predicts not-taken after reset, upper PC bits ignored
        for (int i = 0; i < 16; i++)
            step("sweep", 0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32'hABC0_0000 | (32'(i + 16) << 2) | 32'h3);

        // signed vs unsigned less-than on the same operands
        step("blt",  0, 1, 0, 1, 1, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h104, 0, 32'h104);
        step("bltu", 0, 1, 0, 1, 1, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h104, 0, 32'h104);
        // signed overflow
        step("bge_ovf", 0, 1, 0, 1, 1, 3'b101, 32'h8000_0000, 32'h1, 32'h108, 0, 32'h108);
        step("bne", 0, 1, 0, 1, 1, 3'b001, 32'h7, 32'h7, 32'h108, 1, 32'h108);
        step("bgeu", 0, 1, 0, 1, 1, 3'b111, 32'h0, 32'h0, 32'h108, 0, 32'h108);

        // train idx 0: two with pred=0, then pred tracks lookup (same-cycle lookup)
        step("beq_t0", 0, 1, 0, 1, 1, 3'b000, 32'h9, 32'h9, 32'h40, 0, 32'h40);
        step("beq_t1", 0, 1, 0, 1, 1, 3'b000, 32'h9, 32'h9, 32'h40, 0, 32'h40);
        step("beq_t2", 0, 1, 0, 1, 1, 3'b000, 32'h9, 32'h9, 32'h40, mctr[0][1], 32'h40);
        step("beq_t3", 0, 1, 0, 1, 1, 3'b000, 32'h9, 32'h9, 32'h40, mctr[0][1], 32'h40);

        // stall: outputs frozen, idx 3 counter unchanged
        for (int i = 0; i < 3; i++)
            step("stall", 0, 0, 0, 1, 1, 3'b000, 32'(i), 32'(i), 32'h10C, 1, 32'h10C);
        step("after_stall", 0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32'h10C);
        // flush a taken branch, including flush while stalled
        step("flush", 0, 1, 1, 1, 1, 3'b000, 32'h3, 32'h3, 32'h10C, 0, 32'h10C);
        step("flush_stall", 0, 0, 1, 1, 1, 3'b000, 32'h3, 32'h3, 32'h10C, 0, 32'h10C);
        step("after_flush", 0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32'h10C);

        // non-branch request with a taken prediction
        step("nonbranch", 0, 1, 0, 1, 0, 3'b100, 32'h1, 32'h2, 32'h10C, 1, 32'h10C);
        // reserved codes on a branch: illegal, no update
        step("illegal010", 0, 1, 0, 1, 1, 3'b010, 32'h5, 32'h5, 32'h10C, 0, 32'h10C);
        step("illegal011", 0, 1, 0, 1, 1, 3'b011, 32'h5, 32'h4, 32'h10C, 1, 32'h10C);
        step("idle", 0, 1, 0, 0, 1, 3'b000, 32'h5, 32'h5, 32'h10C, 1, 32'h10C);

        // random mixed traffic
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b, p;
            a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            b = ($urandom_range(0, 2) == 0) ? a : $urandom;
            p = {$urandom_range(0, 255), 2'b00} << 2 >> 2;
            step("rand", 0, $urandom_range(0, 5) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 4) != 0, $urandom_range(0, 5) != 0, 3'($urandom_range(0, 7)),
                 a, b, p, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2);
        end

        // reset overrides en=0 and flush=1; all counters return to weakly not-taken
        step("reset2", 1, 0, 1, 1, 1, 3'b000, 32'h1, 32'h1, 32'h40, 0, 32'h40);
        for (int i = 0; i < 16; i++)
            step("sweep2", 0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32'(i) << 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_cond_unit.md
BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand width in bits; legal values 8..64.
REQ-002 SHALL have parameter BHT_DEPTH, default 16, number of 2-bit predictor counters; power of two, 2..256.
REQ-003 SHALL have parameter IDX_LSB, default 2, lowest PC bit used for the table index; the index is pc[IDX_LSB +: log2(BHT_DEPTH)].
REQ-004 SHALL have one clock and a reset that is synchronous and active-low.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 en  in  1  stage enable; 0 = stall.
REQ-008 flush  in  1  kill the resolve currently being presented.
REQ-009 valid_i  in  1  resolve request valid.
REQ-010 Branch  in  1  request is a conditional branch.
REQ-011 funct3  in  3  branch condition code.
REQ-012 rs1, rs2  in  XLEN  compare operands.
REQ-013 pc_ex  in  XLEN  PC of the resolving instruction.
REQ-014 pred_taken_i  in  1  prediction that fetch made for this instruction.
REQ-015 pc_if  in  XLEN  fetch PC for lookup.
REQ-016 predict_taken  out  1  combinational lookup result, counter[idx(pc_if)][1].
REQ-017 valid_o  out  1  registered result valid.
REQ-018 passcond  out  2  registered; 2'b11 = condition passes, 2'b00 = fails.
REQ-019 taken_o  out  1  registered; branch taken.
REQ-020 mispredict  out  1  registered; taken_o differs from pred_taken_i.
REQ-021 illegal  out  1  registered; reserved funct3 on a branch.
REQ-022 Flags  out  4  registered {N,Z,C,V}.

Function
REQ-023 Compare: diff = {1'b0,rs1} - {1'b0,rs2} in XLEN+1 bits. N=diff[XLEN-1]; Z=(diff[XLEN-1:0]==0); C=~diff[XLEN] (rs1>=rs2 unsigned); V=(rs1[XLEN-1]!=rs2[XLEN-1]) & (diff[XLEN-1]!=rs1[XLEN-1]); ge=(N==V).
REQ-024 Condition by funct3: 000 Z; 001 ~Z; 100 ~ge; 101 ge; 110 ~C; 111 C; 010/011 reserved.
REQ-025 Latency SHALL be 1 cycle: the outputs for a request sampled at edge k SHALL be visible after edge k.
REQ-026 accept = valid_i & en & ~flush.
REQ-027 On accept: valid_o=1 and Flags=computed flags.
REQ-028 On accept with Branch=0: passcond=11, taken_o=0, mispredict=pred_taken_i, illegal=0, no table update.
REQ-029 On accept with Branch=1, legal funct3: passcond=11 if the condition holds, else 00; taken_o=condition; mispredict=(taken_o!=pred_taken_i); illegal=0.
REQ-030 On accept with Branch=1, reserved funct3: passcond=11, taken_o=0, mispredict=pred_taken_i, illegal=1, no table update.
REQ-031 Table update on an accepted legal branch: counter[idx(pc_ex)] +1 if taken, -1 if not, saturating at 00 and 11.
REQ-032 Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
REQ-033 en=0 & flush=0: all output registers hold their values; no table update.
REQ-034 flush=1 (priority over en): next valid_o=0, mispredict=0, illegal=0; no table update; passcond, taken_o and Flags hold.
REQ-035 valid_i=0 & en=1 & flush=0: next valid_o=0, mispredict=0, illegal=0; other outputs hold.
REQ-036 Same-index lookup and update in one cycle: predict_taken SHALL return the pre-update value; the update is visible from the next cycle.
REQ-037 Indexing SHALL wrap modulo BHT_DEPTH; PC bits above and below the index field SHALL be ignored.

Reset
REQ-038 When rst_n=0 at a clock edge: valid_o=0, passcond=00, taken_o=0, mispredict=0, illegal=0, Flags=0000, and every counter SHALL be set to 01.
REQ-039 Reset SHALL override en and flush. A request presented during reset SHALL be discarded.
REQ-040 Predict_taken SHALL read 0 for every index in the cycle after reset.

Verification
REQ-041 Reset, then sweep pc_if over all indices -> predict_taken=0 everywhere; all outputs are 0.
REQ-042 XLEN=32, BLT, rs1=0xFFFFFFFF, rs2=1 -> Flags N=1 Z=0 C=1 V=0, passcond=11, taken_o=1; BLTU with the same operands -> passcond=00, taken_o=0.
REQ-043 Overflow case: BGE, rs1=0x80000000, rs2=1 -> V=1, ge=0, passcond=00.
REQ-044 Four taken BEQ at pc_ex=0x40, equal operands, pred_taken_i=0 -> counter for idx 0 goes 01->10->11->11; mispredict=1, 1, 0, 0 once pred_taken_i tracks predict_taken.
REQ-045 Stall and flush: en=0 for 3 cycles mid-stream -> outputs frozen and the counter is unchanged; flush with a taken branch -> valid_o=0 next cycle and the counter is unchanged.
REQ-046 Edge cases: funct3=010 with Branch=1 -> illegal=1, passcond=11, no table update. Lookup and update to the same index in one cycle -> old value returned.
